// File: rtl/usb_tx_packet.sv
// Low Speed USB packet framer: PID byte, optional payload + CRC16, then a fixed inter-packet gap.
// Latency: tx_valid rises 1 clk after pkt_start; payload bytes reach tx_data 2 clks after each tx_ready.
// Backpressure: advances only on tx_ready pulses; define USB_TX_TOGGLE_EN for DATA0/DATA1 toggle tracking.
module usb_tx_packet #(
  parameter int MAX_LEN  = 8,
  parameter int ADDR_W   = 3,
  parameter int GAP_CLKS = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pkt_start,
  input  logic [3:0]                     pkt_pid,
  input  logic [$clog2(MAX_LEN+1)-1:0]   pkt_len,
`ifdef USB_TX_TOGGLE_EN
  input  logic                           toggle_clr,
  input  logic                           ack_rcvd,
`endif
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [7:0]                     rd_data,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);

  typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI, GAP} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              is_data_q, is_data_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [15:0]       crc_q, crc_d, crc_next;
  logic [1:0]        fetch_q, fetch_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [3:0]        pid_eff;

  // Reflected CRC-16 (0xA001), data bits absorbed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign crc_next = crc16_byte(crc_q, tx_data_q);

`ifdef USB_TX_TOGGLE_EN
  logic toggle_q, toggle_d, armed_q, armed_d;

  // An ACK only counts once the data packet it acknowledges has finished.
  always_comb begin
    toggle_d = toggle_q;
    armed_d  = armed_q;
    if (state_q == IDLE && pkt_start) armed_d = 1'b0;
    if (state_q == GAP && done_d && is_data_q) armed_d = 1'b1;
    if (ack_rcvd && armed_q) begin
      toggle_d = ~toggle_q;
      armed_d  = 1'b0;
    end
    if (toggle_clr) begin
      toggle_d = 1'b0;
      armed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      armed_q  <= armed_d;
    end
  end

  assign pid_eff = (pkt_pid[1:0] == 2'b11) ? {toggle_q, pkt_pid[2:0]} : pkt_pid;
`else
  assign pid_eff = pkt_pid;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rd_addr_d  = rd_addr_q;
    is_data_d  = is_data_q;
    len_d      = len_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    fetch_d    = {fetch_q[0], 1'b0};
    gap_d      = gap_q;
    // Address registered, then RAM registered: data lands two clocks after the request.
    if (fetch_q[1]) tx_data_d = rd_data;
    case (state_q)
      IDLE: if (pkt_start) begin
        state_d    = PID;
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = {~pid_eff, pid_eff};
        rd_addr_d  = '0;
        is_data_d  = (pid_eff[1:0] == 2'b11);
        len_d      = (pkt_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pkt_len;
        idx_d      = '0;
        crc_d      = 16'hFFFF;
      end
      PID: if (tx_ready) begin
        if (!is_data_q) begin
          state_d    = GAP;
          tx_valid_d = 1'b0;
          gap_d      = '0;
        end else if (len_q == '0) begin
          state_d   = CRC_LO;
          tx_data_d = ~crc_q[7:0];
        end else begin
          state_d    = DATA;
          fetch_d[0] = 1'b1;
        end
      end
      DATA: if (tx_ready) begin
        crc_d = crc_next;
        if (idx_q == len_q - 1'b1) begin
          state_d   = CRC_LO;
          tx_data_d = ~crc_next[7:0];
        end else begin
          idx_d      = idx_q + 1'b1;
          rd_addr_d  = ADDR_W'(idx_q + 1'b1);
          fetch_d[0] = 1'b1;
        end
      end
      CRC_LO: if (tx_ready) begin
        state_d   = CRC_HI;
        tx_data_d = ~crc_q[15:8];
      end
      CRC_HI: if (tx_ready) begin
        state_d    = GAP;
        tx_valid_d = 1'b0;
        gap_d      = '0;
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CLKS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rd_addr_q  <= '0;
      is_data_q  <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      crc_q      <= 16'hFFFF;
      fetch_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rd_addr_q  <= rd_addr_d;
      is_data_q  <= is_data_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      fetch_q    <= fetch_d;
      gap_q      <= gap_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_usb_tx_packet.sv
// Bench for usb_tx_packet: table of packets against a sync-RAM and serialiser model, plus reset and toggle sequences.
module tb_usb_tx_packet;

  localparam int MAX_LEN  = 16;
  localparam int ADDR_W   = 4;
  localparam int GAP_CLKS = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_start = 1'b0;
  logic [3:0] pkt_pid = '0;
  logic [4:0] pkt_len = '0;
  logic       busy, done, tx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data, tx_data;
  logic       tx_ready = 1'b0;
`ifdef USB_TX_TOGGLE_EN
  logic       toggle_clr = 1'b0;
  logic       ack_rcvd = 1'b0;
`endif

  usb_tx_packet #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .GAP_CLKS(GAP_CLKS)) dut (
    .clk(clk), .reset(reset), .pkt_start(pkt_start), .pkt_pid(pkt_pid), .pkt_len(pkt_len),
`ifdef USB_TX_TOGGLE_EN
    .toggle_clr(toggle_clr), .ack_rcvd(ack_rcvd),
`endif
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [3:0]       pid;
    logic [4:0]       len;
    logic             ack_pre;
    logic             inj;
    logic [4:0]       n;
    logic [4:0]       n_chk;
    logic [18:0][7:0] exp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  vec_t v;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] got [32];
  int got_n;
  int gap_cnt;
  logic rd_moved;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] pid, input logic [4:0] len, input logic ack,
                              input logic inj, input int n, input int nc);
    vec_t r;
    r = '0;
    r.pid = pid; r.len = len; r.ack_pre = ack; r.inj = inj;
    r.n = 5'(n); r.n_chk = 5'(nc);
    return r;
  endfunction

  // Serialiser model: a ready pulse every 6 clocks while tx_valid is high, then timing of the gap.
  task automatic run_pkt(input logic [3:0] pid, input logic [4:0] len, input logic inj);
    @(negedge clk);
    pkt_pid = pid; pkt_len = len; pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    check("valid_rise", {31'b0, tx_valid}, 1);
    check("busy_rise", {31'b0, busy}, 1);
    got_n = 0;
    rd_moved = 1'b0;
    for (int i = 0; i < 32; i++) got[i] = '0;
    while (tx_valid && got_n < 24) begin
      repeat (5) begin
        @(negedge clk);
        if (rd_addr != '0) rd_moved = 1'b1;
      end
      if (inj && got_n == 4) begin
        pkt_start = 1'b1; pkt_pid = 4'h2;
        @(negedge clk);
        pkt_start = 1'b0;
      end
      got[got_n] = tx_data;
      got_n++;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    gap_cnt = 0;
    while (!done && gap_cnt < 400) begin
      @(negedge clk);
      gap_cnt++;
      pkt_start = (inj && gap_cnt == 10);
      if (!done) check("busy_in_gap", {31'b0, busy}, 1);
    end
    pkt_start = 1'b0;
    check("gap_len", gap_cnt, GAP_CLKS);
    check("busy_at_done", {31'b0, busy}, 0);
    @(negedge clk);
    check("done_one_clk", {31'b0, done}, 0);
    check("idle_after", {30'b0, busy, tx_valid}, 0);
  endtask

`ifdef USB_TX_TOGGLE_EN
  task automatic pulse_ctl(input logic clr, input logic ack);
    @(negedge clk);
    toggle_clr = clr; ack_rcvd = ack;
    @(negedge clk);
    toggle_clr = 1'b0; ack_rcvd = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? 8'(8'h31 + i) : 8'(8'h41 + i);

    vecs[0] = mk(4'h2, 5'd0, 1'b0, 1'b0, 1, 1);    vecs[0].exp[0] = 8'hD2;
    vecs[1] = mk(4'h3, 5'd0, 1'b0, 1'b0, 3, 3);    vecs[1].exp[0] = 8'hC3;
    vecs[2] = mk(4'hB, 5'd9, 1'b1, 1'b1, 12, 12);  vecs[2].exp[0] = 8'h4B;
    for (int i = 0; i < 9; i++) vecs[2].exp[i+1] = 8'(8'h31 + i);
    vecs[2].exp[10] = 8'hC8; vecs[2].exp[11] = 8'hB4;
    vecs[3] = mk(4'h3, 5'd20, 1'b1, 1'b0, 19, 17); vecs[3].exp[0] = 8'hC3;
    for (int i = 0; i < 16; i++) vecs[3].exp[i+1] = mem[i];
    vecs[4] = mk(4'hA, 5'd5, 1'b0, 1'b0, 1, 1);    vecs[4].exp[0] = 8'h5A;
    vecs[5] = mk(4'hE, 5'd0, 1'b0, 1'b0, 1, 1);    vecs[5].exp[0] = 8'h1E;
    vecs[6] = mk(4'h1, 5'd3, 1'b0, 1'b0, 1, 1);    vecs[6].exp[0] = 8'hE1;

    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, tx_valid, rd_addr, tx_data}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
`ifdef USB_TX_TOGGLE_EN
      if (v.ack_pre) pulse_ctl(1'b0, 1'b1);
`endif
      run_pkt(v.pid, v.len, v.inj);
      check($sformatf("v%0d_count", k), got_n, 32'(v.n));
      for (int i = 0; i < int'(v.n_chk); i++)
        check($sformatf("v%0d_byte%0d", k, i), {24'b0, got[i]}, {24'b0, v.exp[i]});
      check($sformatf("v%0d_rd_addr_moved", k), {31'b0, rd_moved}, (v.n > 3) ? 1 : 0);
    end

    // Reset while byte 3 of a data payload is on the bus.
    @(negedge clk);
    pkt_pid = 4'hB; pkt_len = 5'd9; pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (5) @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("byte3_on_bus", {24'b0, tx_data}, 32'h34);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, tx_valid}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("rst_mid_regs", {done, rd_addr, tx_data}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_pkt(4'h2, 5'd0, 1'b0);
    check("post_rst_count", got_n, 1);
    check("post_rst_pid", {24'b0, got[0]}, 32'hD2);

`ifdef USB_TX_TOGGLE_EN
    run_pkt(4'h3, 5'd0, 1'b0);
    check("tog_data0", {24'b0, got[0]}, 32'hC3);
    pulse_ctl(1'b0, 1'b1);
    run_pkt(4'h3, 5'd0, 1'b0);
    check("tog_data1", {24'b0, got[0]}, 32'h4B);
    pulse_ctl(1'b0, 1'b1);
    run_pkt(4'hB, 5'd0, 1'b0);
    check("tog_back0", {24'b0, got[0]}, 32'hC3);
    pulse_ctl(1'b1, 1'b1);
    run_pkt(4'hB, 5'd0, 1'b0);
    check("tog_clr_wins", {24'b0, got[0]}, 32'hC3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
